// File: rtl/intra_blk_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | intra_pkg : shared types and helpers for the intra 4x4 luma fetch  |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package intra_pkg;

    localparam int PIX_W   = 8;
    localparam int MB_SIZE = 16;
    localparam int MBX_W   = 7;
    localparam int MBY_W   = 6;

    typedef logic [127:0] blk4x4_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } fetch_state_t;

    // blkIdx -> {bx[1:0], by[1:0]} in 4x4 units inside the MB (H.264 zig-zag of 8x8 quads)
    function automatic logic [3:0] blk_scan(input logic [3:0] idx);
        return {idx[2], idx[0], idx[3], idx[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/intra_blk_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | intra_blk_fetch_if : frame-memory read port plus block output port |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
interface intra_blk_fetch_if #(
    parameter int ADDR_W = 18
);
    import intra_pkg::*;

    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_rdata;
    logic                blk_valid;
    logic                blk_ready;
    blk4x4_t             blk_data;
    logic [3:0]          blk_idx;
    logic [MBX_W-1:0]    mb_x;
    logic [MBY_W-1:0]    mb_y;

    modport master (
        output mem_rd, mem_addr, blk_valid, blk_data, blk_idx, mb_x, mb_y,
        input  mem_rdata, blk_ready
    );

    modport slave (
        input  mem_rd, mem_addr, blk_valid, blk_data, blk_idx, mb_x, mb_y,
        output mem_rdata, blk_ready
    );

endinterface
`default_nettype wire

// File: rtl/intra_blk_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | intra_blk_addr_gen : MB/blkIdx/row counters and word-address calc  |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module intra_blk_addr_gen
    import intra_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int LENGTH = 720,
    parameter int ADDR_W = 18
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clear_i,
    input  wire logic              row_adv_i,
    input  wire logic              blk_adv_i,
    output logic [1:0]             row_o,
    output logic [3:0]             idx_o,
    output logic [MBX_W-1:0]       mb_x_o,
    output logic [MBY_W-1:0]       mb_y_o,
    output logic [ADDR_W-1:0]      addr_o,
    output logic                   last_row_o,
    output logic                   last_blk_o
);

    localparam int MBW    = WIDTH / MB_SIZE;
    localparam int MBH    = LENGTH / MB_SIZE;
    localparam int WWORDS = WIDTH / 4;

    logic [1:0]       row_q, row_d;
    logic [3:0]       idx_q, idx_d;
    logic [MBX_W-1:0] mbx_q, mbx_d;
    logic [MBY_W-1:0] mby_q, mby_d;

    logic             w_mbx_last;
    logic             w_mby_last;
    logic [3:0]       w_scan;
    logic [ADDR_W-1:0] w_line;
    logic [ADDR_W-1:0] w_col;

    assign w_mbx_last = (mbx_q == MBX_W'(MBW - 1));
    assign w_mby_last = (mby_q == MBY_W'(MBH - 1));

    always_comb begin
        row_d = row_q;
        idx_d = idx_q;
        mbx_d = mbx_q;
        mby_d = mby_q;
        if (clear_i) begin
            row_d = '0;
            idx_d = '0;
            mbx_d = '0;
            mby_d = '0;
        end else begin
            if (row_adv_i) begin
                row_d = row_q + 2'd1;
            end
            if (blk_adv_i) begin
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    if (w_mbx_last) begin
                        mbx_d = '0;
                        mby_d = w_mby_last ? '0 : mby_q + MBY_W'(1);
                    end else begin
                        mbx_d = mbx_q + MBX_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            idx_q <= '0;
            mbx_q <= '0;
            mby_q <= '0;
        end else begin
            row_q <= row_d;
            idx_q <= idx_d;
            mbx_q <= mbx_d;
            mby_q <= mby_d;
        end
    end

    // line = 16*mb_y + 4*by + row ; col = 4*mb_x + bx ; all in ADDR_W bits
    assign w_scan = blk_scan(idx_q);
    assign w_line = ADDR_W'({mby_q, 4'b0000}) + ADDR_W'({w_scan[1:0], 2'b00}) + ADDR_W'(row_q);
    assign w_col  = ADDR_W'({mbx_q, 2'b00}) + ADDR_W'(w_scan[3:2]);
    assign addr_o = w_line * ADDR_W'(WWORDS) + w_col;

    assign row_o      = row_q;
    assign idx_o      = idx_q;
    assign mb_x_o     = mbx_q;
    assign mb_y_o     = mby_q;
    assign last_row_o = (row_q == 2'd3);
    assign last_blk_o = (idx_q == 4'd15) && w_mbx_last && w_mby_last;

endmodule
`default_nettype wire

// File: rtl/intra_blk_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | intra_blk_fetch : raster-MB walker emitting 4x4 luma blocks        |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module intra_blk_fetch
    import intra_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int LENGTH = 720,
    parameter int ADDR_W = 18
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          enable,
    input  wire logic          start,
    intra_blk_fetch_if.master  bus,
    output logic               busy,
    output logic               frame_done
);

    localparam int ROW_W = 4 * PIX_W;

    fetch_state_t          state_q, state_d;
    logic                  w_clear;
    logic                  w_row_adv;
    logic                  w_blk_adv;
    logic [1:0]            w_row;
    logic [3:0]            w_idx;
    logic [MBX_W-1:0]      w_mbx;
    logic [MBY_W-1:0]      w_mby;
    logic [ADDR_W-1:0]     w_addr;
    logic                  w_last_row;
    logic                  w_last_blk;

    logic                  rd_pend_q;
    logic [1:0]            rd_row_q;
    logic [3*ROW_W-1:0]    rows_q;
    blk4x4_t               blk_q;

    intra_blk_addr_gen #(
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (reset),
        .clear_i    (w_clear),
        .row_adv_i  (w_row_adv),
        .blk_adv_i  (w_blk_adv),
        .row_o      (w_row),
        .idx_o      (w_idx),
        .mb_x_o     (w_mbx),
        .mb_y_o     (w_mby),
        .addr_o     (w_addr),
        .last_row_o (w_last_row),
        .last_blk_o (w_last_blk)
    );

    always_comb begin
        state_d   = state_q;
        w_clear   = 1'b0;
        w_row_adv = 1'b0;
        w_blk_adv = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && enable) begin
                    w_clear = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (enable) begin
                    w_row_adv = 1'b1;
                    if (w_last_row) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: state_d = ST_OUT;
            ST_OUT: begin
                if (bus.blk_ready) begin
                    w_blk_adv = 1'b1;
                    state_d   = w_last_blk ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Rows 0..2 park in rows_q; row 3 arrives during DRAIN and goes straight to the output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_q <= 1'b0;
            rd_row_q  <= '0;
            rows_q    <= '0;
            blk_q     <= '0;
        end else begin
            rd_pend_q <= w_row_adv;
            rd_row_q  <= w_row;
            if (rd_pend_q && (rd_row_q != 2'd3)) begin
                rows_q[rd_row_q*ROW_W +: ROW_W] <= bus.mem_rdata;
            end
            if (state_q == ST_DRAIN) begin
                blk_q <= {bus.mem_rdata, rows_q};
            end
        end
    end

    assign bus.mem_rd    = w_row_adv;
    assign bus.mem_addr  = w_addr;
    assign bus.blk_valid = (state_q == ST_OUT);
    assign bus.blk_data  = blk_q;
    assign bus.blk_idx   = w_idx;
    assign bus.mb_x      = w_mbx;
    assign bus.mb_y      = w_mby;
    assign busy          = (state_q == ST_READ) || (state_q == ST_DRAIN) || (state_q == ST_OUT);
    assign frame_done    = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_intra_blk_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_intra_blk_fetch : 1280x720 instance for directed cases, 48x32   |
// | instance for a randomized full frame, both against a pixel model.  |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_intra_blk_fetch;
    import intra_pkg::*;

    localparam int BW = 1280;
    localparam int BL = 720;
    localparam int SW = 48;
    localparam int SL = 32;
    localparam int AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b, en_b, start_b, busy_b, fd_b;
    logic rst_s, en_s, start_s, busy_s, fd_s;

    intra_blk_fetch_if #(.ADDR_W(AW)) bif();
    intra_blk_fetch_if #(.ADDR_W(AW)) sif();

    intra_blk_fetch #(.WIDTH(BW), .LENGTH(BL), .ADDR_W(AW)) u_dut (
        .clk(clk), .reset(rst_b), .enable(en_b), .start(start_b),
        .bus(bif), .busy(busy_b), .frame_done(fd_b)
    );

    intra_blk_fetch #(.WIDTH(SW), .LENGTH(SL), .ADDR_W(AW)) u_dut_small (
        .clk(clk), .reset(rst_s), .enable(en_s), .start(start_s),
        .bus(sif), .busy(busy_s), .frame_done(fd_s)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int      exp_n[2]       = '{0, 0};
    int      hs_cnt[2]      = '{0, 0};
    int      fd_cnt[2]      = '{0, 0};
    int      last_hs_cyc[2] = '{0, 0};
    int      last_rd[2]     = '{0, 0};
    logic    stall_q[2]     = '{1'b0, 1'b0};
    blk4x4_t stall_data[2];
    int      stall_tag[2];
    int      mbw[2]         = '{BW/16, SW/16};
    int      total[2]       = '{(BW/16)*(BL/16)*16, (SW/16)*(SL/16)*16};

    int      rd_addr_q[$];
    int      rd_cyc_q[$];
    blk4x4_t hs_data_q[$];
    int      first_val_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pix(int x, int y);
        return 8'((x + 3*y) & 255);
    endfunction

    function automatic logic [31:0] word_at(int w, int a);
        int y, x0;
        logic [31:0] v;
        y  = a / (w/4);
        x0 = (a % (w/4)) * 4;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = pix(x0 + k, y);
        return v;
    endfunction

    // Expected block from the pixel formula and the blkIdx quad-tree order.
    function automatic blk4x4_t ref_blk(int mbx, int mby, int idx);
        int bx, by;
        blk4x4_t b;
        bx = (idx % 2) + 2*((idx/4) % 2);
        by = ((idx/2) % 2) + 2*(idx/8);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[32*r + 8*c +: 8] = pix(16*mbx + 4*bx + c, 16*mby + 4*by + r);
        return b;
    endfunction

    function automatic int addr_at(int i);
        if (i < rd_addr_q.size()) return rd_addr_q[i];
        return -1;
    endfunction

    function automatic int cyc_at(int i);
        if (i < rd_cyc_q.size()) return rd_cyc_q[i];
        return -1;
    endfunction

    function automatic blk4x4_t hs_at(int i);
        if (i < hs_data_q.size()) return hs_data_q[i];
        return '0;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (bif.mem_rd) bif.mem_rdata <= word_at(BW, int'(bif.mem_addr));
        if (sif.mem_rd) sif.mem_rdata <= word_at(SW, int'(sif.mem_addr));
    end

    task automatic mon(input int w, input logic rst, input logic en, input logic rd, input int addr,
                       input logic valid, input logic ready, input blk4x4_t data,
                       input int idx, input int mbx, input int mby, input logic fd);
        int k, mb, tag;
        tag = idx*65536 + mbx*256 + mby;
        if (!rst) begin
            exp_n[w]   = 0;
            stall_q[w] = 1'b0;
        end else begin
            if (rd) begin
                check("rd_only_when_enabled", en, 1'b1);
                check("no_rd_while_valid", valid, 1'b0);
                last_rd[w] = addr;
                if (w == 0) begin
                    rd_addr_q.push_back(addr);
                    rd_cyc_q.push_back(cyc);
                end
            end
            if (stall_q[w]) begin
                check("hold_valid", valid, 1'b1);
                check("hold_data", data, stall_data[w]);
                check("hold_tag", tag, stall_tag[w]);
            end
            if (valid && (w == 0) && (first_val_cyc < 0)) first_val_cyc = cyc;
            stall_q[w]    = valid && !ready;
            stall_data[w] = data;
            stall_tag[w]  = tag;
            if (valid && ready) begin
                k  = exp_n[w];
                mb = k / 16;
                check("blk_data", data, ref_blk(mb % mbw[w], mb / mbw[w], k % 16));
                check("blk_tag", tag, (k % 16)*65536 + (mb % mbw[w])*256 + mb / mbw[w]);
                exp_n[w]++;
                hs_cnt[w]++;
                last_hs_cyc[w] = cyc;
                if (w == 0) hs_data_q.push_back(data);
            end
            if (fd) begin
                fd_cnt[w]++;
                check("fd_after_last_hs", cyc - last_hs_cyc[w], 1);
                check("fd_block_count", exp_n[w], total[w]);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, rst_b, en_b, bif.mem_rd, int'(bif.mem_addr), bif.blk_valid, bif.blk_ready,
            bif.blk_data, int'(bif.blk_idx), int'(bif.mb_x), int'(bif.mb_y), fd_b);
        mon(1, rst_s, en_s, sif.mem_rd, int'(sif.mem_addr), sif.blk_valid, sif.blk_ready,
            sif.blk_data, int'(sif.blk_idx), int'(sif.mb_x), int'(sif.mb_y), fd_s);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_big_zero(input string tag);
        check({tag, "_data"}, bif.blk_data, '0);
        check({tag, "_ctrl"}, {bif.mem_rd, bif.mem_addr, bif.blk_valid, bif.blk_idx,
                               bif.mb_x, bif.mb_y, busy_b, fd_b}, '0);
    endtask

    initial begin
        int n, rd_before, tag_before;
        blk4x4_t b, data_before;

        rst_b = 1'b0; rst_s = 1'b0;
        en_b = 1'b0; en_s = 1'b0; start_b = 1'b0; start_s = 1'b0;
        bif.blk_ready = 1'b0; sif.blk_ready = 1'b0;
        repeat (3) tick();
        check_big_zero("reset");
        rst_b = 1'b1; rst_s = 1'b1;
        tick();

        // First blocks of the 1280x720 frame with ready held high
        en_b = 1'b1; bif.blk_ready = 1'b1; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("t1_busy", busy_b, 1'b1);
        n = 0;
        while (hs_cnt[0] < 6 && n < 200) begin tick(); n++; end
        check("t1_six_blocks", hs_cnt[0] >= 6, 1'b1);
        for (int r = 0; r < 4; r++) begin
            check("t1_row_addr", addr_at(r), 320*r);
            check("t1_row_cycle", cyc_at(r) - cyc_at(0), r);
        end
        check("t1_latency", first_val_cyc - cyc_at(0), 5);
        check("t1_block_period", cyc_at(4) - cyc_at(0), 6);
        b = hs_at(0);
        check("t1_row0", b[31:0], 32'h03020100);
        check("t1_row1", b[63:32], 32'h06050403);
        check("t2_idx5_addr", addr_at(20), 3);
        b = hs_at(5);
        check("t2_idx5_row0", b[31:0], 32'h0F0E0D0C);

        // Back-pressure: valid block held for 10 cycles
        bif.blk_ready = 1'b0;
        n = 0;
        while (!bif.blk_valid && n < 50) begin tick(); n++; end
        check("t3_valid_seen", bif.blk_valid, 1'b1);
        rd_before   = rd_addr_q.size();
        data_before = bif.blk_data;
        tag_before  = int'(bif.blk_idx)*65536 + int'(bif.mb_x)*256 + int'(bif.mb_y);
        repeat (10) tick();
        check("t3_no_reads", rd_addr_q.size(), rd_before);
        check("t3_data_stable", bif.blk_data, data_before);
        check("t3_tag_stable", int'(bif.blk_idx)*65536 + int'(bif.mb_x)*256 + int'(bif.mb_y), tag_before);
        bif.blk_ready = 1'b1;

        // Reset in the middle of READ
        n = 0;
        while (!bif.mem_rd && n < 50) begin tick(); n++; end
        check("t6_in_read", bif.mem_rd, 1'b1);
        rst_b = 1'b0;
        #1;
        check_big_zero("t6_async");
        repeat (2) tick();
        check_big_zero("t6_hold");
        rst_b = 1'b1;
        tick();
        rd_addr_q.delete(); rd_cyc_q.delete(); hs_data_q.delete(); first_val_cyc = -1;

        // Restart with enable toggling every cycle
        en_b = 1'b1; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (exp_n[0] < 1 && n < 100) begin
            tick();
            en_b = ~en_b;
            n++;
        end
        check("t5_first_block", exp_n[0] >= 1, 1'b1);
        for (int r = 0; r < 4; r++) begin
            check("t5_row_addr", addr_at(r), 320*r);
            check("t5_row_cycle", cyc_at(r) - cyc_at(0), 2*r);
        end
        check("t5_blk0", hs_at(0), ref_blk(0, 0, 0));
        en_b = 1'b0;

        // Full 48x32 frame with random enable, ready and stray start pulses
        en_s = 1'b1; sif.blk_ready = 1'b0; start_s = 1'b1;
        tick();
        n = 0;
        while (fd_cnt[1] == 0 && n < 20000) begin
            en_s          = ($urandom_range(0, 3) != 0);
            sif.blk_ready = ($urandom_range(0, 2) != 0);
            start_s       = ($urandom_range(0, 15) == 0);
            tick();
            n++;
        end
        start_s = 1'b0;
        repeat (5) tick();
        check("s_handshakes", hs_cnt[1], total[1]);
        check("s_fd_pulses", fd_cnt[1], 1);
        check("s_busy_after", busy_s, 1'b0);
        check("s_last_addr", last_rd[1], (SW*SL)/4 - 1);
        check("big_no_fd", fd_cnt[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
